mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single main-memory port between the instruction cache (read-only)
//  and data_cache (read refill + dirty write-back).
//  Each request is accepted, sequenced against a fixed-latency memory and
//  answered with a one-cycle ack.
//  Sits between both caches and main memory. Cache stalls are held by the
//  caches until their ack arrives.
// PARAMETERS
//  XLEN     32  address/data width
//  MEM_LAT  2   memory read latency in cycles (>=1). Writes use the same timing.
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     asynchronous reset, active-low
//  i_req      in   1     icache read request, held until i_ack
//  i_addr     in   XLEN  icache word address
//  i_ack      out  1     one-cycle pulse: i_rdata valid
//  i_rdata    out  XLEN  icache read data
//  d_req      in   1     dcache request, held until d_ack
//  d_we       in   1     1 = write-back, 0 = refill read
//  d_addr     in   XLEN  dcache word address
//  d_wdata    in   XLEN  dcache write data
//  d_ack      out  1     one-cycle pulse: write done / d_rdata valid
//  d_rdata    out  XLEN  dcache read data
//  mem_addr   out  XLEN  address to memory
//  mem_wd     out  XLEN  write data to memory
//  mem_wr_en  out  1     memory write enable
//  mem_rd_en  out  1     memory read enable
//  mem_rd     in   XLEN  memory read data, valid MEM_LAT cycles after the first mem_rd_en cycle
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=IDLE, cnt=0, last_grant=I.
//   - All outputs are 0, including i_rdata and d_rdata.
//   - An in-flight access is abandoned; mem_wr_en drops immediately.
//  FSM IDLE -> ACCESS -> RESP -> IDLE.
//  IDLE:
//   - If any request is high, latch owner, addr, we and wdata.
//   - Load cnt=MEM_LAT-1 and go to ACCESS.
//   - Memory outputs are 0.
//  Arbitration (IDLE only):
//   - If only one requester is active, it wins.
//   - If both are active, round-robin: grant the one that is not last_grant.
//     After reset last_grant=I, so D wins the first tie.
//   - last_grant updates on every grant.
//  ACCESS:
//   - mem_addr, mem_wd and mem_wr_en/mem_rd_en are driven from the latched
//     registers and stay stable for all MEM_LAT cycles.
//   - cnt decrements each cycle.
//   - When cnt==0: capture mem_rd into the owner's rdata register (reads only),
//     then go to RESP.
//  RESP:
//   - Assert the owner's ack for exactly one cycle.
//   - The other ack stays 0. Memory enables are 0. Go to IDLE.
//  Latency:
//   - Request seen in IDLE at edge T -> ack high in cycle T+MEM_LAT+1.
//   - Minimum request-to-request spacing is MEM_LAT+2 cycles.
//  rdata registers hold their value until the next read for that port.
//  Requesters must drop req at the edge ending the ack cycle. A req that is
//  still high in IDLE is treated as a new request.
//  Dropping req during ACCESS does not abort: the access completes and ack
//  still pulses.
//  Request signal changes during ACCESS/RESP are ignored, because the latched
//  copies are used.
//  i_ack and d_ack are never both high. mem_wr_en and mem_rd_en are never both high.
// TESTING
//  - MEM_LAT=2, i_req with i_addr=0x100, memory returns 0xDEADBEEF
//    -> mem_rd_en high for 2 cycles; i_ack pulses once, 3 cycles after
//    acceptance, with i_rdata=0xDEADBEEF.
//  - d_req, d_we=1, d_addr=0x2004, d_wdata=0x12345678
//    -> mem_wr_en high for 2 cycles with that addr/data; d_ack pulses once;
//    d_rdata unchanged.
//  - i_req and d_req rise together after reset, both held
//    -> grant order D, I, D, I; no ack overlap.
//  - d_req alone three times back-to-back
//    -> D granted each time; spacing is MEM_LAT+2 cycles.
//  - rst=0 mid-ACCESS on a write
//    -> mem_wr_en drops in the same cycle with no clock; no ack;
//    the next request after release is served normally.
//  - i_req dropped during ACCESS -> i_ack still pulses; FSM returns to IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one fixed-latency main-memory port between the
//                instruction cache (reads only) and the data cache (refill
//                reads and dirty write-backs). Each request is latched in
//                IDLE, held on the memory port for MEM_LAT cycles in ACCESS,
//                and answered with a single-cycle ack in RESP. Ties between
//                the two caches are broken round-robin.
//  Ports       : clk, rst (async, active-low)
//                i_req/i_addr -> i_ack/i_rdata           icache side
//                d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata  dcache side
//                mem_addr/mem_wd/mem_wr_en/mem_rd_en <- mem_rd  memory side
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int XLEN    = 32,
    parameter int MEM_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_ack,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_ack,
    output logic [XLEN-1:0] d_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wd,
    output logic            mem_wr_en,
    output logic            mem_rd_en,
    input  logic [XLEN-1:0] mem_rd
);

    localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic [1:0]       state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q,      owner_d;
    logic             we_q,         we_d;
    logic [XLEN-1:0]  addr_q,       addr_d;
    logic [XLEN-1:0]  wdata_q,      wdata_d;
    logic [XLEN-1:0]  i_rdata_q,    i_rdata_d;
    logic [XLEN-1:0]  d_rdata_q,    d_rdata_d;

    // D wins when it is the only requester, or on a tie when I was served last.
    logic w_grant_is_d;
    assign w_grant_is_d = d_req && (!i_req || (last_grant_q == OWN_I));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    owner_d      = w_grant_is_d ? OWN_D : OWN_I;
                    last_grant_d = w_grant_is_d ? OWN_D : OWN_I;
                    addr_d       = w_grant_is_d ? d_addr : i_addr;
                    we_d         = w_grant_is_d && d_we;
                    wdata_d      = w_grant_is_d ? d_wdata : '0;
                    cnt_d        = CNT_LOAD;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    // Last access cycle: memory data is valid now.
                    if (!we_q) begin
                        if (owner_q == OWN_D) begin
                            d_rdata_d = mem_rd;
                        end else begin
                            i_rdata_d = mem_rd;
                        end
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_grant_q <= OWN_I;
            owner_q      <= OWN_I;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Memory port is decoded from state so an async reset clears it at once.
    logic w_access;
    logic w_resp;
    assign w_access = (state_q == S_ACCESS);
    assign w_resp   = (state_q == S_RESP);

    assign mem_addr  = w_access ? addr_q  : '0;
    assign mem_wd    = w_access ? wdata_q : '0;
    assign mem_wr_en = w_access && we_q;
    assign mem_rd_en = w_access && !we_q;

    assign i_ack   = w_resp && (owner_q == OWN_I);
    assign d_ack   = w_resp && (owner_q == OWN_D);
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule
`default_nettype wire
